// File: rtl/magcompare_pkg.sv
// Shared types and helpers for the pipelined magnitude comparator:
// comparison modes, the (gt,lt) tree pair, per-operand sideband and final resolution.
package magcompare_pkg;

    typedef enum logic [1:0] {
        CMP_UNSIGNED = 2'd0,
        CMP_SIGNED   = 2'd1,
        CMP_SIGNMAG  = 2'd2,
        CMP_RSVD     = 2'd3
    } cmp_mode_t;

    typedef struct packed {
        logic gt;
        logic lt;
    } cmp_pair_t;

    // Information that must travel alongside the tree to resolve the final order.
    typedef struct packed {
        cmp_mode_t mode;
        logic      sign_a;
        logic      sign_b;
        logic      both_zero;
    } cmp_side_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_result_t;

    function automatic cmp_pair_t leaf_compare(input logic [1:0] a, input logic [1:0] b);
        cmp_pair_t p;
        p.gt = (a > b);
        p.lt = (a < b);
        return p;
    endfunction

    // Intermediate register i (0..stages-2) sits after tree level i*(levels-1)/(stages-1);
    // level 0 always gets the first one and the last level never does.
    function automatic bit reg_after_level(input int level, input int levels, input int stages);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < stages - 1; i++) begin
            if ((i * (levels - 1)) / (stages - 1) == level) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic cmp_result_t resolve(input cmp_pair_t p, input cmp_side_t s);
        cmp_result_t r;
        r.gt = p.gt;
        r.lt = p.lt;
        if (s.mode == CMP_SIGNMAG) begin
            if (s.sign_a != s.sign_b) begin
                // +0 and -0 compare equal; otherwise the negative operand is the smaller one.
                r.gt = ~s.sign_a & ~s.both_zero;
                r.lt =  s.sign_a & ~s.both_zero;
            end else if (s.sign_a) begin
                r.gt = p.lt;
                r.lt = p.gt;
            end
        end
        r.eq = ~r.gt & ~r.lt;
        return r;
    endfunction

endpackage

// File: rtl/magcompare_node.sv
// Combinational merge cell of the comparison tree: the higher-order pair
// decides unless it reports equal, in which case the lower-order pair does.
module magcompare_node
    import magcompare_pkg::*;
(
    input  cmp_pair_t hi,
    input  cmp_pair_t lo,
    output cmp_pair_t res
);

    assign res = (hi.gt | hi.lt) ? hi : lo;

endmodule

// File: rtl/magcompare_pipe.sv
// Pipelined tree magnitude comparator (unsigned / two's complement / sign-magnitude)
// with a valid/ready handshake where every stage advances together.
module magcompare_pipe
    import magcompare_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  cmp_mode_t        mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             LT,
    output logic             EQ,
    output logic             GT
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int LEAVES = WIDTH / 2;

    logic              adv;
    logic [WIDTH-1:0]  a_eff;
    logic [WIDTH-1:0]  b_eff;
    cmp_side_t         side_in;
    cmp_side_t         side_pre;
    logic              valid_pre;
    logic [STAGES-1:0] valid_q;
    cmp_pair_t         root;
    cmp_result_t       res_q;

    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign out_valid = valid_q[STAGES-1];

    // Reshape the MSBs so a plain unsigned tree yields the order each mode needs.
    always_comb begin
        a_eff = A;
        b_eff = B;
        case (mode)
            CMP_SIGNED: begin
                a_eff[WIDTH-1] = ~A[WIDTH-1];
                b_eff[WIDTH-1] = ~B[WIDTH-1];
            end
            CMP_SIGNMAG: begin
                a_eff[WIDTH-1] = 1'b0;
                b_eff[WIDTH-1] = 1'b0;
            end
            default: ;
        endcase
    end

    assign side_in.mode      = mode;
    assign side_in.sign_a    = A[WIDTH-1];
    assign side_in.sign_b    = B[WIDTH-1];
    assign side_in.both_zero = ~|{A[WIDTH-2:0], B[WIDTH-2:0]};

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int N = LEAVES >> k;
        cmp_pair_t cur [N];
        cmp_pair_t nxt [N];

        if (k == 0) begin : g_leaf
            for (genvar j = 0; j < N; j++) begin : g_n
                assign cur[j] = leaf_compare(a_eff[2*j +: 2], b_eff[2*j +: 2]);
            end
        end else begin : g_merge
            for (genvar j = 0; j < N; j++) begin : g_n
                magcompare_node u_node (
                    .hi  (g_lvl[k-1].nxt[2*j+1]),
                    .lo  (g_lvl[k-1].nxt[2*j]),
                    .res (cur[j])
                );
            end
        end

        if (reg_after_level(k, LEVELS, STAGES)) begin : g_reg
            // NOTE: data-path registers have no reset; the valid bits alone decide
            // whether their contents mean anything, so clearing them buys nothing.
            always_ff @(posedge clk) begin
                if (adv) nxt <= cur;
            end
        end else begin : g_pass
            assign nxt = cur;
        end
    end

    assign root = g_lvl[LEVELS-1].nxt[0];

    if (STAGES == 1) begin : g_side_direct
        assign side_pre  = side_in;
        assign valid_pre = in_valid;
    end else begin : g_side_pipe
        cmp_side_t side_q [STAGES-1];

        always_ff @(posedge clk) begin
            if (adv) begin
                side_q[0] <= side_in;
                for (int i = 1; i < STAGES - 1; i++) side_q[i] <= side_q[i-1];
            end
        end

        assign side_pre  = side_q[STAGES-2];
        assign valid_pre = valid_q[STAGES-2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            res_q   <= '0;
        end else if (adv) begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) valid_q[i] <= valid_q[i-1];
            res_q <= valid_pre ? resolve(root, side_pre) : '0;
        end
    end

    assign LT = res_q.lt;
    assign EQ = res_q.eq;
    assign GT = res_q.gt;

endmodule

// File: doc/magcompare_pipe.md
MAGCOMPARE_PIPE -- requirements
Module: magcompare_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand width; power of two, 4..128.
REQ-002 Parameter STAGES, default 2, pipeline register count; 1..log2(WIDTH).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts operand set this cycle.
REQ-007 A  input  WIDTH  first operand.
REQ-008 B  input  WIDTH  second operand.
REQ-009 mode  input  2  cmp_mode_t: 0 UNSIGNED, 1 SIGNED (two's complement), 2 SIGNMAG (sign-magnitude/FP ordering), 3 reserved.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 LT, EQ, GT  output  1 each  A<B, A==B, A>B under captured mode.

Function
REQ-013 Transfer in on in_valid&in_ready; out on out_valid&out_ready.
REQ-014 Pipeline advance enable adv = out_ready | ~out_valid; in_ready = adv, combinational, no other input dependency.
REQ-015 All stages shift together when adv=1; all hold when adv=0; bubbles (in_valid=0 while adv) enter as invalid stages.
REQ-016 Latency exactly STAGES cycles from accept to out_valid with no backpressure; throughput one result per cycle.
REQ-017 Results emerge strictly in acceptance order; none dropped or duplicated.
REQ-018 Tree: WIDTH/2 2-bit leaf compares produce (gt,lt) pairs; log2(WIDTH)-1 combining levels, each merging adjacent pairs, higher-order pair dominant unless it reports equal.
REQ-019 Pipeline registers placed after leaf level and after evenly spaced combining levels; final register drives outputs; mode and sign information travel with the data.
REQ-020 UNSIGNED: plain magnitude order.
REQ-021 SIGNED: MSBs of A and B inverted before leaf compare.
REQ-022 SIGNMAG: magnitude compare on bits WIDTH-2:0; signs differ -> negative operand is less, except both magnitudes zero -> EQ; both negative -> LT and GT swapped.
REQ-023 Mode 3 treated as UNSIGNED.
REQ-024 Exactly one of LT/EQ/GT is 1 when out_valid=1; all three 0 when out_valid=0.
REQ-025 Outputs and out_valid stable while out_valid&~out_ready.

Reset
REQ-026 reset asserted: all stage valid bits and LT/EQ/GT clear immediately, independent of clk.
REQ-027 Reset mid-operation discards all in-flight operands; no result for them appears after release.
REQ-028 First accept possible on first rising edge after reset deasserts; in_ready follows REQ-014 during reset.

Structure
REQ-029 Package magcompare_pkg holds cmp_mode_t enum and the (gt,lt) pair struct type.
REQ-030 Sub-module magcompare_node: combinational 2-pair merge cell, instantiated per tree node via generate loops.
REQ-031 Data-path registers carry no reset; only valid bits and outputs are reset.

Verification
REQ-032 WIDTH=32, STAGES=2, UNSIGNED: A=0x80000000, B=0x7FFFFFFF accepted cycle 0 -> GT=1, out_valid cycle 2.
REQ-033 SIGNED, same operands -> LT=1; A=B=0xFFFFFFFF -> EQ=1.
REQ-034 SIGNMAG: A=0x80000000, B=0x00000000 -> EQ=1; A=0xBF800000 (-1.0), B=0xC0000000 (-2.0) -> GT=1.
REQ-035 Back-to-back 4 transactions, out_ready=0 for 3 cycles after first result -> in_ready=0 during stall, outputs held, all 4 results delivered in order.
REQ-036 reset pulsed with 2 transactions in flight -> out_valid=0 immediately, no stale result after release.
REQ-037 Random 10k operands all modes, STAGES 1..5 -> match reference model, one-hot outputs.
